// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: TX/RX byte FIFOs between the bus and spi_master, with levels, irqs and sticky error flags.
module spi_byte_fifo_core #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o,
  output logic          udf_o
);
  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;
  assign full_o  = level_q == {1'b1, {AW{1'b0}}};
  assign empty_o = level_q == '0;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign ovf_o   = push_i & full_o & ~flush_i;
  assign udf_o   = pop_i & empty_o & ~flush_i;
  assign head_o  = mem_q[rd_q];
  assign level_o = level_q;
  always_comb begin
    rd_d    = flush_i ? '0 : rd_q + AW'(pop_ok);
    wr_d    = flush_i ? '0 : wr_q + AW'(push_ok);
    level_d = flush_i ? '0 : level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  // Storage is not reset; a flushed push must not land in the array either.
  always_ff @(posedge clk)
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
endmodule

module spi_byte_fifo #(
  parameter int AW     = 4,
  parameter int TX_THR = 4,
  parameter int RX_THR = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tx_flush,
  input  logic          rx_flush,
  input  logic          err_clr,
  input  logic          tx_wr_en,
  input  logic [7:0]    tx_wr_data,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  input  logic          rx_rd_en,
  output logic [7:0]    rx_rd_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          tx_buf_vld,
  output logic [7:0]    tx_buf_byte,
  input  logic          tx_buf_req,
  output logic          rx_buf_vld,
  input  logic [7:0]    rx_buf_byte,
  input  logic          rx_buf_req,
  output logic          tx_irq,
  output logic          rx_irq,
  output logic [3:0]    err_flags
);
  logic       tx_empty, rx_full, tx_ovf, tx_udf, rx_ovf, rx_udf;
  logic [3:0] err_q, err_d;
  spi_byte_fifo_core #(.AW(AW)) u_tx (
    .clk(clk), .rstn(rstn), .flush_i(tx_flush), .push_i(tx_wr_en), .data_i(tx_wr_data),
    .pop_i(tx_buf_req), .head_o(tx_buf_byte), .level_o(tx_level), .full_o(tx_full),
    .empty_o(tx_empty), .ovf_o(tx_ovf), .udf_o(tx_udf)
  );
  spi_byte_fifo_core #(.AW(AW)) u_rx (
    .clk(clk), .rstn(rstn), .flush_i(rx_flush), .push_i(rx_buf_req), .data_i(rx_buf_byte),
    .pop_i(rx_rd_en), .head_o(rx_rd_data), .level_o(rx_level), .full_o(rx_full),
    .empty_o(rx_empty), .ovf_o(rx_ovf), .udf_o(rx_udf)
  );
  assign tx_buf_vld = ~tx_empty;
  assign rx_buf_vld = ~rx_full;
  assign tx_irq     = tx_level <= (AW+1)'(TX_THR);
  assign rx_irq     = rx_level >= (AW+1)'(RX_THR);
  assign err_flags  = err_q;
  // New errors are OR-ed after the clear so a same-cycle event survives err_clr.
  always_comb err_d = (err_clr ? 4'b0 : err_q) | {rx_udf, rx_ovf, tx_udf, tx_ovf};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err_q <= '0;
    else err_q <= err_d;
endmodule

// File: tb/tb_spi_byte_fifo.sv
// tb_spi_byte_fifo: directed and random stimulus checked against a queue-based model of the byte FIFOs.
module tb_spi_byte_fifo;
  logic       clk = 0, rstn = 0;
  logic       tx_flush = 0, rx_flush = 0, err_clr = 0, tx_wr_en = 0, rx_rd_en = 0;
  logic       tx_buf_req = 0, rx_buf_req = 0;
  logic [7:0] tx_wr_data = 0, rx_buf_byte = 0;
  logic       tx_full, rx_empty, tx_buf_vld, rx_buf_vld, tx_irq, rx_irq;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rx_rd_data, tx_buf_byte;
  logic [3:0] err_flags;
  int         total = 0, bad = 0;
  logic [7:0] txq[$], rxq[$];
  logic [3:0] m_err = 0;

  spi_byte_fifo #(.AW(4), .TX_THR(4), .RX_THR(4)) dut (
    .clk(clk), .rstn(rstn), .tx_flush(tx_flush), .rx_flush(rx_flush), .err_clr(err_clr),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .tx_buf_vld(tx_buf_vld), .tx_buf_byte(tx_buf_byte), .tx_buf_req(tx_buf_req),
    .rx_buf_vld(rx_buf_vld), .rx_buf_byte(rx_buf_byte), .rx_buf_req(rx_buf_req),
    .tx_irq(tx_irq), .rx_irq(rx_irq), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tx_level", 32'(tx_level), txq.size());
    chk("rx_level", 32'(rx_level), rxq.size());
    chk("tx_full", 32'(tx_full), 32'(txq.size() == 16));
    chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    chk("tx_buf_vld", 32'(tx_buf_vld), 32'(txq.size() != 0));
    chk("rx_buf_vld", 32'(rx_buf_vld), 32'(rxq.size() != 16));
    chk("tx_irq", 32'(tx_irq), 32'(txq.size() <= 4));
    chk("rx_irq", 32'(rx_irq), 32'(rxq.size() >= 4));
    chk("err_flags", 32'(err_flags), 32'(m_err));
    if (txq.size() != 0) chk("tx_buf_byte", 32'(tx_buf_byte), 32'(txq[0]));
    if (rxq.size() != 0) chk("rx_rd_data", 32'(rx_rd_data), 32'(rxq[0]));
  endtask

  // One clock with the given inputs; the model decides outcomes from the pre-edge occupancy.
  task automatic step(input logic tw, input logic [7:0] td, input logic tr, input logic rp,
                      input logic [7:0] rb, input logic rr, input logic tf, input logic rf,
                      input logic ec);
    logic [3:0] e;
    bit tpush, tpop, rpush, rpop;
    tx_wr_en = tw; tx_wr_data = td; tx_buf_req = tr; rx_buf_req = rp; rx_buf_byte = rb;
    rx_rd_en = rr; tx_flush = tf; rx_flush = rf; err_clr = ec;
    e = 0;
    tpush = tw && txq.size() < 16; tpop = tr && txq.size() > 0;
    rpush = rp && rxq.size() < 16; rpop = rr && rxq.size() > 0;
    if (tf) txq.delete();
    else begin
      e[0] = tw && !tpush; e[1] = tr && !tpop;
      if (tpop) void'(txq.pop_front());
      if (tpush) txq.push_back(td);
    end
    if (rf) rxq.delete();
    else begin
      e[2] = rp && !rpush; e[3] = rr && !rpop;
      if (rpop) void'(rxq.pop_front());
      if (rpush) rxq.push_back(rb);
    end
    m_err = (ec ? 4'b0 : m_err) | e;
    @(posedge clk);
    #1;
    tx_wr_en = 0; tx_buf_req = 0; rx_buf_req = 0; rx_rd_en = 0;
    tx_flush = 0; rx_flush = 0; err_clr = 0;
    check_all();
  endtask

  task automatic tpush(input logic [7:0] d); step(1, d, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tpop();                     step(0, 0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic rpush(input logic [7:0] d); step(0, 0, 0, 1, d, 0, 0, 0, 0); endtask
  task automatic rpop();                     step(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_tx_irq", 32'(tx_irq), 1);
    chk("reset_rx_buf_vld", 32'(rx_buf_vld), 1);
    rstn = 1;
    @(posedge clk); #1;
    // Two-byte TX transfer
    tpush(8'hA5); tpush(8'h3C);
    chk("tx_head_a5", 32'(tx_buf_byte), 32'hA5);
    tpop();
    chk("tx_head_3c", 32'(tx_buf_byte), 32'h3C);
    chk("tx_level_1", 32'(tx_level), 1);
    tpop();
    chk("tx_vld_drop", 32'(tx_buf_vld), 0);
    // Fill TX, then overflow with 0xFF
    for (int i = 0; i < 16; i++) tpush(8'(i * 7 + 1));
    tpush(8'hFF);
    chk("tx_full_16", 32'(tx_full), 1);
    chk("tx_ovf", 32'(err_flags[0]), 1);
    // Push + pop while full: push rejected, pop accepted
    step(1, 8'hEE, 1, 0, 0, 0, 0, 0, 0);
    chk("tx_level_15", 32'(tx_level), 15);
    while (txq.size() != 0) begin
      chk("tx_never_ff", 32'(tx_buf_byte != 8'hFF && tx_buf_byte != 8'hEE), 1);
      tpop();
    end
    // Fill RX, overflow, drain, underflow
    for (int i = 0; i < 16; i++) rpush(8'($urandom_range(0, 255)));
    rpush(8'h77);
    chk("rx_ovf", 32'(err_flags[2]), 1);
    chk("rx_vld_full", 32'(rx_buf_vld), 0);
    for (int i = 0; i < 16; i++) rpop();
    rpop();
    chk("rx_udf", 32'(err_flags[3]), 1);
    // Flush beats a concurrent push and raises nothing
    for (int i = 0; i < 5; i++) tpush(8'(8'h40 + i));
    step(1, 8'h55, 0, 0, 0, 0, 1, 0, 0);
    chk("flush_level", 32'(tx_level), 0);
    chk("flush_err", 32'(err_flags), 32'b1101);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("err_clr", 32'(err_flags), 0);
    // Clear and a new stale-pop error in the same cycle: set wins
    step(0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("clr_set_wins", 32'(err_flags), 32'b0010);
    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    // Asynchronous reset mid-traffic empties both FIFOs at once
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 1, 8'(i), 0, 0, 0, 0);
    #2 rstn = 0;
    #1;
    txq.delete(); rxq.delete(); m_err = 0;
    check_all();
    chk("async_tx_level", 32'(tx_level), 0);
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    tpush(8'h99);
    chk("post_reset_head", 32'(tx_buf_byte), 32'h99);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
